// File: rtl/cap_pkg.sv
// cap_pkg: definitions shared by the result writer and its line FIFO.
//   rw_state_e        - result_writer FSM state encoding
//   RESULT_W          - width of one DNN result line / memory write beat
//   ADDR_W_DEF        - default width of the result line address
//   FIFO_DEPTH_DEF    - default number of buffered result lines
//   NUM_W             - width of the result line count
`timescale 1ns/1ps
package cap_pkg;

    typedef enum logic [1:0] {
        RW_IDLE    = 2'd0,
        RW_RUN     = 2'd1,
        RW_WAIT_WR = 2'd2,
        RW_FINISH  = 2'd3
    } rw_state_e;

    localparam int RESULT_W       = 512;
    localparam int ADDR_W_DEF     = 28;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int NUM_W          = 12;

endpackage

// File: rtl/rslt_fifo.sv
// rslt_fifo: synchronous DEPTH x WIDTH FIFO holding result lines.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push       - write push_data at the tail (never asserted while full)
//   push_data  - line to store
//   pop        - drop the head entry (never asserted while empty)
//   head       - oldest stored line
//   full/empty - occupancy flags from the registered count
`timescale 1ns/1ps
module rslt_fifo
    import cap_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = RESULT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/result_writer.sv
// result_writer: collects num_results DNN result lines through a small FIFO
// and writes them one at a time to consecutive line addresses in memory.
//   clk, rst             - clock, synchronous active-high reset
//   start                - one-cycle pulse: latch rslt_base_addr/num_results
//   rslt_base_addr       - address of the first result line
//   num_results          - number of lines to collect and write
//   dnnResVld/dnnResults - result line from the DNN
//   dnnResRdy            - line is accepted this cycle when valid is high
//   write_request_valid  - one-cycle memory write request
//   address/write_data   - write address and payload, held until write_done
//   write_done           - memory write completion pulse
//   busy                 - transfer in progress
//   done                 - one-cycle pulse after the last line is written
`timescale 1ns/1ps
module result_writer
    import cap_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   rslt_base_addr,
    input  logic [NUM_W-1:0]    num_results,
    input  logic                dnnResVld,
    input  logic [RESULT_W-1:0] dnnResults,
    output logic                dnnResRdy,
    output logic                write_request_valid,
    output logic [31:0]         address,
    output logic [RESULT_W-1:0] write_data,
    input  logic                write_done,
    output logic                busy,
    output logic                done
);

    rw_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [NUM_W-1:0]    accepted_q, accepted_d;
    logic [NUM_W-1:0]    written_q, written_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_vld_q, wr_vld_d;
    logic [31:0]         addr_q, addr_d;
    logic [RESULT_W-1:0] wdata_q, wdata_d;

    logic                push, pop;
    logic                fifo_full, fifo_empty;
    logic [RESULT_W-1:0] fifo_head;
    logic [ADDR_W-1:0]   line_addr;

    // Ready depends only on registered state, never on dnnResVld.
    assign dnnResRdy = busy_q & ~fifo_full & (accepted_q < num_q);
    assign push      = dnnResVld & dnnResRdy;

    // Line address wraps modulo 2**ADDR_W.
    assign line_addr = base_q + ADDR_W'(written_q);

    rslt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (dnnResults),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        accepted_d = accepted_q + NUM_W'(push);
        written_d  = written_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_vld_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pop        = 1'b0;

        case (state_q)
            RW_IDLE: begin
                if (start) begin
                    base_d     = rslt_base_addr;
                    num_d      = num_results;
                    accepted_d = '0;
                    written_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = RW_RUN;
                end
            end
            RW_RUN: begin
                if (written_q >= num_q) begin
                    // Only reachable directly for num_results == 0.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = RW_FINISH;
                end else if (!fifo_empty || push) begin
                    // A line arriving into an empty FIFO is forwarded straight
                    // into the write register so the request leaves next cycle.
                    wr_vld_d = 1'b1;
                    addr_d   = 32'(line_addr);
                    wdata_d  = fifo_empty ? dnnResults : fifo_head;
                    state_d  = RW_WAIT_WR;
                end
            end
            RW_WAIT_WR: begin
                if (write_done) begin
                    pop       = 1'b1;
                    written_d = written_q + NUM_W'(1);
                    if (written_d == num_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = RW_FINISH;
                    end else begin
                        state_d = RW_RUN;
                    end
                end
            end
            RW_FINISH: begin
                state_d = RW_IDLE;
            end
            default: begin
                state_d = RW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RW_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_vld_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_vld_q   <= wr_vld_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign write_request_valid = wr_vld_q;
    assign address             = addr_q;
    assign write_data          = wdata_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_result_writer.sv
`timescale 1ns/1ps
module tb_result_writer;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [27:0]  rslt_base_addr;
    logic [11:0]  num_results;
    logic         dnnResVld;
    logic [511:0] dnnResults;
    logic         dnnResRdy;
    logic         write_request_valid;
    logic [31:0]  address;
    logic [511:0] write_data;
    logic         write_done;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    // Observations collected by run_xfer
    int           n_wr;
    logic [31:0]  wr_addr [16];
    logic [511:0] wr_data [16];
    int           wr_cyc  [16];
    int           acc_cyc [16];
    int           n_acc;
    int           n_done;
    int           done_cyc;
    int           rdy_cnt;
    int           peak_out;
    int           rdy_full_viol;
    int           rdy_missing;
    bit           timed_out;

    result_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(28)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .rslt_base_addr      (rslt_base_addr),
        .num_results         (num_results),
        .dnnResVld           (dnnResVld),
        .dnnResults          (dnnResults),
        .dnnResRdy           (dnnResRdy),
        .write_request_valid (write_request_valid),
        .address             (address),
        .write_data          (write_data),
        .write_done          (write_done),
        .busy                (busy),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [511:0] pat(input int k, input logic [31:0] salt);
        logic [511:0] v;
        v = '0;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = salt ^ {8'(k), 8'(w), 16'h5AC3};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [27:0] base, input logic [11:0] num);
        rslt_base_addr = base;
        num_results    = num;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    // Plays DNN source and memory for one transfer, beginning the cycle after
    // start (cyc 1). Memory answers each request 'delay' cycles later.
    task automatic run_xfer(input int num, input int offer, input int delay, input int budget,
                            input int abort_wr, input int stray_cyc, input int restart_cyc,
                            input logic [31:0] salt);
        int wd_at;
        int wdone;
        int outst;
        bit ended;
        n_wr = 0; n_acc = 0; n_done = 0; done_cyc = -1; rdy_cnt = 0;
        peak_out = 0; rdy_full_viol = 0; rdy_missing = 0;
        wd_at = -1; wdone = 0; ended = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (write_request_valid) begin
                if (n_wr < 16) begin
                    wr_addr[n_wr] = address;
                    wr_data[n_wr] = write_data;
                    wr_cyc[n_wr]  = cyc;
                end
                n_wr++;
                wd_at = cyc + delay;
                if (abort_wr >= 0 && n_wr - 1 == abort_wr) begin
                    ended = 1'b1;
                    break;
                end
            end
            if (done) begin
                n_done++;
                if (n_done == 1) done_cyc = cyc;
            end
            if (n_done > 0 && cyc >= done_cyc + 3) begin
                ended = 1'b1;
                break;
            end
            if (dnnResRdy) rdy_cnt++;
            outst = n_acc - wdone;
            if (outst > peak_out) peak_out = outst;
            if (dnnResRdy && outst >= DEPTH) rdy_full_viol++;
            if (busy && !done && n_acc < num && outst < DEPTH && !dnnResRdy) rdy_missing++;
            write_done = (cyc == wd_at) || (cyc == stray_cyc);
            if (cyc == wd_at) wdone++;
            start = (cyc == restart_cyc);
            if (start) begin
                rslt_base_addr = 28'h0999999;
                num_results    = 12'd7;
            end
            dnnResVld  = (n_acc < offer);
            dnnResults = pat(n_acc, salt);
            if (dnnResVld && dnnResRdy) begin
                if (n_acc < 16) acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
        end
        timed_out  = !ended;
        write_done = 1'b0;
        start      = 1'b0;
        dnnResVld  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dnnResVld = 1'b1; write_done = 1'b1;
        rslt_base_addr = 28'h1234567; num_results = 12'd5;
        dnnResults = pat(0, 32'h1);
        repeat (3) tick();
        n_cmp++; if (dnnResRdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b expected 0", dnnResRdy); end
        n_cmp++; if (write_request_valid !== 1'b0) begin n_err++; $display("FAIL reset_wrv: got %b expected 0", write_request_valid); end
        n_cmp++; if (address !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", address); end
        n_cmp++; if (write_data !== 512'h0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", write_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0; start = 1'b0; dnnResVld = 1'b0; write_done = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_start(28'h0000100, 12'd3);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
        run_xfer(3, 5, 2, 200, -1, -1, -1, 32'h1111_0000);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %b expected 0", timed_out); end
        n_cmp++; if (n_wr !== 3) begin n_err++; $display("FAIL basic_nwr: got %0d expected 3", n_wr); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_addr[i] !== 32'(32'h100 + i)) begin n_err++; $display("FAIL basic_addr%0d: got %h expected %h", i, wr_addr[i], 32'(32'h100 + i)); end
            n_cmp++; if (wr_data[i] !== pat(i, 32'h1111_0000)) begin n_err++; $display("FAIL basic_data%0d: got %h expected %h", i, wr_data[i], pat(i, 32'h1111_0000)); end
            n_cmp++; if (wr_cyc[i] !== 2 + 4 * i) begin n_err++; $display("FAIL basic_wrcyc%0d: got %0d expected %0d", i, wr_cyc[i], 2 + 4 * i); end
        end
        n_cmp++; if (wr_cyc[0] !== acc_cyc[0] + 1) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", wr_cyc[0], acc_cyc[0] + 1); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL basic_ndone: got %0d expected 1", n_done); end
        n_cmp++; if (done_cyc !== 13) begin n_err++; $display("FAIL basic_donecyc: got %0d expected 13", done_cyc); end
        n_cmp++; if (n_acc !== 3) begin n_err++; $display("FAIL basic_accepted: got %0d expected 3", n_acc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        do_start(28'h0000800, 12'd6);
        run_xfer(6, 8, 20, 400, -1, -1, -1, 32'h2222_0000);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
        n_cmp++; if (n_wr !== 6) begin n_err++; $display("FAIL bp_nwr: got %0d expected 6", n_wr); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (wr_addr[i] !== 32'(32'h800 + i)) begin n_err++; $display("FAIL bp_addr%0d: got %h expected %h", i, wr_addr[i], 32'(32'h800 + i)); end
            n_cmp++; if (wr_data[i] !== pat(i, 32'h2222_0000)) begin n_err++; $display("FAIL bp_data%0d: got %h expected %h", i, wr_data[i], pat(i, 32'h2222_0000)); end
        end
        n_cmp++; if (peak_out !== DEPTH) begin n_err++; $display("FAIL bp_peak: got %0d expected %0d", peak_out, DEPTH); end
        n_cmp++; if (rdy_full_viol !== 0) begin n_err++; $display("FAIL bp_rdy_full: got %0d expected 0", rdy_full_viol); end
        n_cmp++; if (rdy_missing !== 0) begin n_err++; $display("FAIL bp_rdy_reassert: got %0d expected 0", rdy_missing); end
        n_cmp++; if (n_acc !== 6) begin n_err++; $display("FAIL bp_accepted: got %0d expected 6", n_acc); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL bp_ndone: got %0d expected 1", n_done); end
    endtask

    task automatic test_zero();
        do_start(28'h0000500, 12'd0);
        run_xfer(0, 2, 2, 50, -1, -1, -1, 32'h3333_0000);
        n_cmp++; if (done_cyc !== 2) begin n_err++; $display("FAIL zero_donecyc: got %0d expected 2", done_cyc); end
        n_cmp++; if (n_wr !== 0) begin n_err++; $display("FAIL zero_nwr: got %0d expected 0", n_wr); end
        n_cmp++; if (rdy_cnt !== 0) begin n_err++; $display("FAIL zero_rdy: got %0d expected 0", rdy_cnt); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL zero_ndone: got %0d expected 1", n_done); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        exp_a = '{32'h0FFFFFFE, 32'h0FFFFFFF, 32'h00000000};
        do_start(28'hFFFFFFE, 12'd3);
        run_xfer(3, 3, 1, 200, -1, -1, -1, 32'h4444_0000);
        n_cmp++; if (n_wr !== 3) begin n_err++; $display("FAIL wrap_nwr: got %0d expected 3", n_wr); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr%0d: got %h expected %h", i, wr_addr[i], exp_a[i]); end
        end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL wrap_ndone: got %0d expected 1", n_done); end
    endtask

    task automatic test_reset_mid();
        int stray;
        do_start(28'h0000200, 12'd4);
        run_xfer(4, 4, 2, 200, 1, -1, -1, 32'h5555_0000);
        n_cmp++; if (n_wr !== 2) begin n_err++; $display("FAIL rmid_reached: got %0d expected 2", n_wr); end
        rst = 1'b1; dnnResVld = 1'b1;
        tick();
        n_cmp++; if ({dnnResRdy, write_request_valid, busy, done} !== 4'b0) begin n_err++; $display("FAIL rmid_ctrl: got %b expected 0000", {dnnResRdy, write_request_valid, busy, done}); end
        n_cmp++; if (address !== 32'h0) begin n_err++; $display("FAIL rmid_addr: got %h expected 0", address); end
        n_cmp++; if (write_data !== 512'h0) begin n_err++; $display("FAIL rmid_wdata: got %h expected 0", write_data); end
        rst = 1'b0; dnnResVld = 1'b0; write_done = 1'b1;
        tick();
        write_done = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (write_request_valid || busy || done || dnnResRdy) stray++;
            tick();
        end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL rmid_quiet: got %0d active cycles expected 0", stray); end
        do_start(28'h0000040, 12'd1);
        run_xfer(1, 1, 2, 100, -1, -1, -1, 32'h6666_0000);
        n_cmp++; if (n_wr !== 1) begin n_err++; $display("FAIL rmid_new_nwr: got %0d expected 1", n_wr); end
        n_cmp++; if (wr_addr[0] !== 32'h40) begin n_err++; $display("FAIL rmid_new_addr: got %h expected 00000040", wr_addr[0]); end
        n_cmp++; if (wr_data[0] !== pat(0, 32'h6666_0000)) begin n_err++; $display("FAIL rmid_new_data: got %h expected %h", wr_data[0], pat(0, 32'h6666_0000)); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL rmid_new_ndone: got %0d expected 1", n_done); end
    endtask

    task automatic test_ignored_inputs();
        do_start(28'h0000300, 12'd2);
        run_xfer(2, 4, 3, 200, -1, 1, 3, 32'h7777_0000);
        n_cmp++; if (n_wr !== 2) begin n_err++; $display("FAIL ign_nwr: got %0d expected 2", n_wr); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (wr_addr[i] !== 32'(32'h300 + i)) begin n_err++; $display("FAIL ign_addr%0d: got %h expected %h", i, wr_addr[i], 32'(32'h300 + i)); end
            n_cmp++; if (wr_data[i] !== pat(i, 32'h7777_0000)) begin n_err++; $display("FAIL ign_data%0d: got %h expected %h", i, wr_data[i], pat(i, 32'h7777_0000)); end
        end
        n_cmp++; if (done_cyc !== 11) begin n_err++; $display("FAIL ign_donecyc: got %0d expected 11", done_cyc); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL ign_ndone: got %0d expected 1", n_done); end
        n_cmp++; if (n_acc !== 2) begin n_err++; $display("FAIL ign_accepted: got %0d expected 2", n_acc); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rslt_base_addr = '0; num_results = '0;
        dnnResVld = 1'b0; dnnResults = '0; write_done = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_ignored_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
